// File: rtl/sipo_baud_rx_pkg.sv
// Shared serial-path definitions: state encodings and default frame geometry.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a; the PISO and this receiver both take their defaults from here.
package sipo_baud_rx_pkg;

  // Defaults shared with the baud PISO so both ends of the link agree.
  localparam int DEF_DATA_W       = 8;
  localparam int DEF_CLKS_PER_BIT = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // Counter width for a count of n states, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sipo_baud_rx_bit_phase_cnt.sv
// Per-bit phase counter: marks the mid-bit sample cycle and the last cycle of each bit.
// Latency: ticks are combinational from the current phase; phase advances on each enabled clk.
// Backpressure: none; clear holds the phase at 0, enable lets it run and wrap at the last cycle.
module bit_phase_cnt
  import sipo_baud_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic sample_tick,
  output logic bit_tick
);

  localparam int PW = cnt_w(CLKS_PER_BIT);
  localparam logic [PW-1:0] SAMPLE = PW'(CLKS_PER_BIT / 2);
  localparam logic [PW-1:0] LAST   = PW'(CLKS_PER_BIT - 1);

  logic [PW-1:0] phase;

  // Phase runs 0..LAST while enabled and returns to 0 on the last cycle of a bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= '0;
    end else if (clear) begin
      phase <= '0;
    end else if (enable) begin
      phase <= (phase == LAST) ? '0 : phase + 1'b1;
    end
  end

  assign sample_tick = enable && (phase == SAMPLE);
  assign bit_tick    = enable && (phase == LAST);

endmodule

// File: rtl/sipo_baud_rx.sv
// Baud-timed SIPO receiver: rebuilds an MSB-first word and holds it until acknowledged.
// Latency: start in cycle T -> dout/dout_valid visible in cycle T+DATA_W*CLKS_PER_BIT+1.
// Backpressure: none upstream; an unacked word is overwritten by the next frame and overrun is set.
module sipo_baud_rx
  import sipo_baud_rx_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              din,
  input  logic              ack,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              busy,
  output logic              overrun,
  output logic              start_err
);

  localparam int BW = cnt_w(DATA_W);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

  state_t            state, state_nxt;
  logic [BW-1:0]     bitcnt;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] shreg_in;
  logic [DATA_W-1:0] word;
  logic              in_shift;
  logic              sample_tick;
  logic              bit_tick;
  logic              frame_end;

  assign in_shift  = (state == ST_SHIFT);
  assign busy      = in_shift;
  assign start_err = in_shift && start;
  assign frame_end = bit_tick && (bitcnt == BIT_LAST);
  assign shreg_in  = {shreg[DATA_W-2:0], din};
  // When the sample and last-cycle ticks coincide the final bit is not yet in shreg.
  assign word      = sample_tick ? shreg_in : shreg;

  bit_phase_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_phase (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (!in_shift),
    .enable     (in_shift),
    .sample_tick(sample_tick),
    .bit_tick   (bit_tick)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: a start while idle opens a frame; the last cycle of the last bit closes it.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_SHIFT;
      ST_SHIFT: if (frame_end) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Bit counter and shift register; starts while shifting never touch them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bitcnt <= '0;
      shreg  <= '0;
    end else if (!in_shift) begin
      bitcnt <= '0;
    end else begin
      if (sample_tick) shreg <= shreg_in;
      if (bit_tick)    bitcnt <= frame_end ? '0 : bitcnt + 1'b1;
    end
  end

  // Output hold: load on frame end, clear on ack, flag a word lost without an ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      overrun    <= 1'b0;
    end else if (frame_end) begin
      dout       <= word;
      dout_valid <= 1'b1;
      if (dout_valid && !ack)     overrun <= 1'b1;
      else if (dout_valid && ack) overrun <= 1'b0;
    end else if (ack && dout_valid) begin
      dout_valid <= 1'b0;
      overrun    <= 1'b0;
    end
  end

endmodule
